// File: rtl/rv32i_run_pkg.sv
// Shared types for the RV32I run controller: the top-level sequencing states.
package rv32i_run_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESET = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } run_state_e;

endpackage

// File: rtl/rv32i_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; used for both the reset-phase
// timer and the run-cycle counter of rv32i_run_ctrl.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/rv32i_run_ctrl.sv
// Run controller for a set of RV32I cores: holds them in reset, runs them until
// every core halts or a cycle budget expires, then freezes them for inspection.
//
// state | meaning
// IDLE  | cores held in reset, waiting for start
// RESET | cores held in reset for RESET_CYCLES cycles
// RUN   | cores enabled until all halt or budget expires
// DONE  | cores frozen (not reset), results held
module rv32i_run_ctrl
    import rv32i_run_pkg::*;
#(
    parameter int N_CORES      = 1,
    parameter int RESET_CYCLES = 2,
    parameter int MAX_CYCLES   = 10,
    parameter int CNT_W        = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [N_CORES-1:0] halt_req,
    output logic               core_rst,
    output logic [N_CORES-1:0] core_ena,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [CNT_W-1:0]   cycles,
    output logic [N_CORES-1:0] halted_mask
);

    localparam int              PH_W     = $clog2(RESET_CYCLES) + 1;
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(MAX_CYCLES - 1);

    run_state_e         state, state_nxt;
    logic [PH_W-1:0]    ph_cnt;
    logic [N_CORES-1:0] mask_nxt;
    logic               all_halt;
    logic               budget_hit;
    logic               run_clr;

    // Halts requested this cycle count toward the exit decision immediately.
    assign mask_nxt   = halted_mask | halt_req;
    assign all_halt   = &mask_nxt;
    assign budget_hit = (cycles == CYC_LAST);
    assign run_clr    = ((state == IDLE) || (state == DONE)) && start && !abort;

    sat_counter #(.WIDTH(PH_W)) u_phase (
        .clk   (clk),
        .rst   (rst),
        .clr   (state != RESET),
        .inc   (state == RESET),
        .count (ph_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_cycles (
        .clk   (clk),
        .rst   (rst),
        .clr   (run_clr),
        .inc   ((state == RUN) && !abort),
        .count (cycles)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = RESET;
                RESET:   if (ph_cnt == PH_LAST) state_nxt = RUN;
                RUN:     if (all_halt || budget_hit) state_nxt = DONE;
                DONE:    if (start) state_nxt = RESET;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // A final halt coinciding with budget expiry is a clean finish, not a timeout.
    always_ff @(posedge clk) begin
        if (!rst) begin
            halted_mask <= '0;
            timeout     <= 1'b0;
        end else if (abort) begin
            timeout <= 1'b0;
        end else if (run_clr) begin
            halted_mask <= '0;
            timeout     <= 1'b0;
        end else if (state == RUN) begin
            halted_mask <= mask_nxt;
            if (budget_hit && !all_halt) timeout <= 1'b1;
        end
    end

    always_comb begin
        core_rst = (state == IDLE) || (state == RESET);
        core_ena = (state == RUN) ? ~halted_mask : '0;
        busy     = (state == RESET) || (state == RUN);
        done     = (state == DONE);
    end

endmodule

// File: tb/tb_rv32i_run_ctrl.sv
// Bench for rv32i_run_ctrl: a two-core and a single-core instance run side by
// side, checked against a run-level model (halt cycle per core -> trace/result).
module tb_rv32i_run_ctrl;

    localparam int MAXC = 10;
    localparam int RC   = 2;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [1:0]  h2;
    logic [0:0]  h1;

    logic        d2_core_rst, d2_busy, d2_done, d2_timeout;
    logic [1:0]  d2_core_ena, d2_mask;
    logic [31:0] d2_cycles;
    logic        d1_core_rst, d1_busy, d1_done, d1_timeout;
    logic [0:0]  d1_core_ena, d1_mask;
    logic [31:0] d1_cycles;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rv32i_run_ctrl #(.N_CORES(2), .RESET_CYCLES(RC), .MAX_CYCLES(MAXC), .CNT_W(32)) dut2 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .halt_req(h2),
        .core_rst(d2_core_rst), .core_ena(d2_core_ena), .busy(d2_busy), .done(d2_done),
        .timeout(d2_timeout), .cycles(d2_cycles), .halted_mask(d2_mask)
    );

    rv32i_run_ctrl #(.N_CORES(1), .RESET_CYCLES(RC), .MAX_CYCLES(MAXC), .CNT_W(32)) dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .halt_req(h1),
        .core_rst(d1_core_rst), .core_ena(d1_core_ena), .busy(d1_busy), .done(d1_done),
        .timeout(d1_timeout), .cycles(d1_cycles), .halted_mask(d1_mask)
    );

    wire [39:0] obs2 = {d2_core_rst, d2_core_ena, d2_busy, d2_done, d2_timeout, d2_cycles, d2_mask};
    wire [39:0] obs1 = {d1_core_rst, 1'b0, d1_core_ena, d1_busy, d1_done, d1_timeout,
                        d1_cycles, 1'b0, d1_mask};

    // Halt cycle 0 means "never halts".
    function automatic int eff(int h);
        return (h == 0) ? MAXC + 100 : h;
    endfunction

    function automatic logic [39:0] idle_vec(int cyc, logic [1:0] msk);
        return {1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 32'(cyc), msk};
    endfunction

    // Expected outputs sampled during run cycle k (or after the run has ended).
    function automatic logic [39:0] expect_run(int ha, int hb, bit two, int k);
        int ea, eb, last, len;
        logic [1:0] ena, msk;
        logic to;
        ea   = eff(ha);
        eb   = two ? eff(hb) : 0;
        last = (ea > eb) ? ea : eb;
        len  = (last > MAXC) ? MAXC : last;
        to   = (last > MAXC);
        if (k <= len) begin
            msk = {two && (eb < k), ea < k};
            ena = ~msk;
            if (!two) ena[1] = 1'b0;
            return {1'b0, ena, 1'b1, 1'b0, 1'b0, 32'(k - 1), msk};
        end
        msk = {two && (eb <= len), ea <= len};
        return {1'b0, 2'b00, 1'b0, 1'b1, to, 32'(len), msk};
    endfunction

    function automatic int run_len(int ha, int hb, bit two);
        int last;
        last = eff(ha);
        if (two && eff(hb) > last) last = eff(hb);
        return (last > MAXC) ? MAXC : last;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start from IDLE/DONE and check the reset phase; ends at run cycle 1.
    task automatic pulse_start(string tag);
        logic [39:0] e;
        start = 1'b1;
        h2 = '0;
        h1 = '0;
        step();
        for (int r = 1; r <= RC; r++) begin
            e = {1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 32'd0, 2'b00};
            total++;
            if (obs2 !== e) begin
                bad++;
                $display("FAIL %s reset_phase%0d dut2 got=%h want=%h", tag, r, obs2, e);
            end
            total++;
            if (obs1 !== e) begin
                bad++;
                $display("FAIL %s reset_phase%0d dut1 got=%h want=%h", tag, r, obs1, e);
            end
            start = 1'($urandom % 2);
            h2    = 2'($urandom % 4);
            h1    = 1'($urandom % 2);
            step();
        end
    endtask

    // Check run cycles 1..kstop; inputs for cycle kstop stay driven on return.
    task automatic run_phase(int ha, int hb, int hs, int kstop, string tag);
        logic [39:0] e2, e1;
        int minl;
        minl = run_len(ha, hb, 1'b1);
        if (run_len(hs, 0, 1'b0) < minl) minl = run_len(hs, 0, 1'b0);
        for (int k = 1; k <= kstop; k++) begin
            e2 = expect_run(ha, hb, 1'b1, k);
            e1 = expect_run(hs, 0, 1'b0, k);
            total++;
            if (obs2 !== e2) begin
                bad++;
                $display("FAIL %s run_k%0d dut2 got=%h want=%h", tag, k, obs2, e2);
            end
            total++;
            if (obs1 !== e1) begin
                bad++;
                $display("FAIL %s run_k%0d dut1 got=%h want=%h", tag, k, obs1, e1);
            end
            h2[0] = (eff(ha) == k) || (eff(ha) < k && ($urandom % 2) == 1);
            h2[1] = (eff(hb) == k) || (eff(hb) < k && ($urandom % 2) == 1);
            h1[0] = (eff(hs) == k) || (eff(hs) < k && ($urandom % 2) == 1);
            start = (k <= minl) ? 1'($urandom % 2) : 1'b0;
            if (k < kstop) step();
        end
    endtask

    task automatic full_run(int ha, int hb, int hs, string tag);
        int l2, l1;
        l2 = run_len(ha, hb, 1'b1);
        l1 = run_len(hs, 0, 1'b0);
        pulse_start(tag);
        run_phase(ha, hb, hs, ((l2 > l1) ? l2 : l1) + 1, tag);
        start = 1'b0;
        h2 = '0;
        h1 = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; abort = 1'b0; h2 = '0; h1 = '0;
        step();
        step();
        rst = 1'b1;
        step();
        total++;
        if (obs2 !== idle_vec(0, 2'b00)) begin
            bad++;
            $display("FAIL reset dut2 got=%h want=%h", obs2, idle_vec(0, 2'b00));
        end
        total++;
        if (obs1 !== idle_vec(0, 2'b00)) begin
            bad++;
            $display("FAIL reset dut1 got=%h want=%h", obs1, idle_vec(0, 2'b00));
        end
    endtask

    task automatic test_default();
        full_run(0, 0, 0, "default");
    endtask

    // dut2: halts in cycles 3 and 6; dut1: halt coincides with budget expiry.
    task automatic test_halts();
        full_run(3, 6, MAXC, "halts");
    endtask

    task automatic test_abort_done();
        full_run(0, 0, 0, "pre_abort");
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        total++;
        if (obs2 !== idle_vec(MAXC, 2'b00)) begin
            bad++;
            $display("FAIL abort_done dut2 got=%h want=%h", obs2, idle_vec(MAXC, 2'b00));
        end
        total++;
        if (obs1 !== idle_vec(MAXC, 2'b00)) begin
            bad++;
            $display("FAIL abort_done dut1 got=%h want=%h", obs1, idle_vec(MAXC, 2'b00));
        end
        full_run(4, 0, 7, "rerun");
    endtask

    task automatic test_rst_midrun();
        pulse_start("rst_mid");
        run_phase(2, 0, 0, 5, "rst_mid");
        rst = 1'b0;
        start = 1'b1;
        step();
        rst = 1'b1;
        start = 1'b0;
        h2 = '0;
        h1 = '0;
        total++;
        if (obs2 !== idle_vec(0, 2'b00)) begin
            bad++;
            $display("FAIL rst_mid dut2 got=%h want=%h", obs2, idle_vec(0, 2'b00));
        end
        total++;
        if (obs1 !== idle_vec(0, 2'b00)) begin
            bad++;
            $display("FAIL rst_mid dut1 got=%h want=%h", obs1, idle_vec(0, 2'b00));
        end
        step();
        total++;
        if (obs2 !== idle_vec(0, 2'b00)) begin
            bad++;
            $display("FAIL rst_mid_hold dut2 got=%h want=%h", obs2, idle_vec(0, 2'b00));
        end
    endtask

    task automatic test_abort_midrun();
        pulse_start("abort_mid");
        run_phase(2, 0, 0, 4, "abort_mid");
        abort = 1'b1;
        start = 1'b1;
        h2 = 2'b11;
        h1 = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        h2 = '0;
        h1 = '0;
        total++;
        if (obs2 !== idle_vec(3, 2'b01)) begin
            bad++;
            $display("FAIL abort_mid dut2 got=%h want=%h", obs2, idle_vec(3, 2'b01));
        end
        total++;
        if (obs1 !== idle_vec(3, 2'b00)) begin
            bad++;
            $display("FAIL abort_mid dut1 got=%h want=%h", obs1, idle_vec(3, 2'b00));
        end
    endtask

    task automatic test_random();
        int ha, hb, hs;
        for (int n = 0; n < 12; n++) begin
            ha = $urandom_range(0, MAXC + 3);
            hb = $urandom_range(0, MAXC + 3);
            hs = $urandom_range(0, MAXC + 3);
            full_run(ha, hb, hs, "random");
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_halts();
        test_abort_done();
        test_rst_midrun();
        test_abort_midrun();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
